// File: rtl/seq_divider.sv
// Sequential signed restoring divider: WIDTH_FP-bit dividend / WIDTH_IN-bit divisor,
// one quotient bit per cycle, start/done handshake with sign fix-up in a final cycle.
module seq_divider #(
  parameter int unsigned WIDTH_IN = 16,
  parameter int unsigned WIDTH_FP = 32,
  parameter int unsigned WIDTH_CO = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH_FP-1:0] dividend,
  input  logic [WIDTH_IN-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [WIDTH_IN-1:0] quotient,
  output logic [WIDTH_IN-1:0] remainder,
  output logic                div_zero,
  output logic                overflow
);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_FIX} state_t;

  localparam logic [WIDTH_FP-1:0] LIM_NEG = WIDTH_FP'(1) << (WIDTH_IN - 1);
  localparam logic [WIDTH_FP-1:0] LIM_POS = LIM_NEG - WIDTH_FP'(1);
  localparam logic [WIDTH_IN-1:0] Q_OVF   = WIDTH_IN'(1) << (WIDTH_IN - 1);

  state_t              r_state;
  state_t              w_next;
  logic [WIDTH_FP-1:0] r_dvd;
  logic [WIDTH_IN-1:0] r_dsr;
  logic [WIDTH_IN-1:0] r_acc;
  logic [WIDTH_CO-1:0] r_cnt;
  logic                r_sign_n;
  logic                r_sign_q;
  logic                r_dz;
  logic                r_done;
  logic [WIDTH_IN-1:0] r_quot;
  logic [WIDTH_IN-1:0] r_rem;
  logic                r_dz_o;
  logic                r_ovf;

  logic [WIDTH_FP-1:0] w_dvd_abs;
  logic [WIDTH_IN-1:0] w_dsr_abs;
  logic                w_dsr_zero;
  logic [WIDTH_IN:0]   w_acc_sh;
  logic [WIDTH_IN:0]   w_diff;
  logic                w_ge;
  logic                w_last;
  logic                w_ovf;
  logic [WIDTH_IN-1:0] w_q_signed;
  logic [WIDTH_IN-1:0] w_r_signed;

  // r_dvd starts as |dividend| and is shifted out MSB-first while quotient bits fill its LSB
  assign w_dvd_abs  = dividend[WIDTH_FP-1] ? (-dividend) : dividend;
  assign w_dsr_abs  = divisor[WIDTH_IN-1] ? (-divisor) : divisor;
  assign w_dsr_zero = (divisor == '0);
  assign w_acc_sh   = {r_acc, r_dvd[WIDTH_FP-1]};
  assign w_diff     = w_acc_sh - {1'b0, r_dsr};
  assign w_ge       = ~w_diff[WIDTH_IN];
  assign w_last     = (r_cnt == WIDTH_CO'(WIDTH_FP - 1));
  assign w_ovf      = r_sign_q ? (r_dvd > LIM_NEG) : (r_dvd > LIM_POS);
  assign w_q_signed = r_sign_q ? (-r_dvd[WIDTH_IN-1:0]) : r_dvd[WIDTH_IN-1:0];
  assign w_r_signed = r_sign_n ? (-r_acc) : r_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = w_dsr_zero ? S_FIX : S_DIVIDE;
      S_DIVIDE: if (w_last) w_next = S_FIX;
      S_FIX:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = r_done;
    quotient  = r_quot;
    remainder = r_rem;
    div_zero  = r_dz_o;
    overflow  = r_ovf;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign_n <= 1'b0;
      r_sign_q <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dz_o   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd    <= w_dvd_abs;
            r_dsr    <= w_dsr_abs;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign_n <= dividend[WIDTH_FP-1];
            r_sign_q <= dividend[WIDTH_FP-1] ^ divisor[WIDTH_IN-1];
            r_dz     <= w_dsr_zero;
          end
        end
        S_DIVIDE: begin
          r_acc <= w_ge ? w_diff[WIDTH_IN-1:0] : w_acc_sh[WIDTH_IN-1:0];
          r_dvd <= {r_dvd[WIDTH_FP-2:0], w_ge};
          r_cnt <= r_cnt + WIDTH_CO'(1);
        end
        S_FIX: begin
          if (r_dz) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dz_o <= 1'b1;
            r_ovf  <= 1'b0;
          end else if (w_ovf) begin
            r_quot <= Q_OVF;
            r_rem  <= '0;
            r_dz_o <= 1'b0;
            r_ovf  <= 1'b1;
          end else begin
            r_quot <= w_q_signed;
            r_rem  <= w_r_signed;
            r_dz_o <= 1'b0;
            r_ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: sign combinations, overflow edges, divide-by-zero,
// ignored start while busy, mid-operation reset and back-to-back operation.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH_IN(16), .WIDTH_FP(32), .WIDTH_CO(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operation, scramble operands while busy, optionally pulse start at
  // cycle 'poke' of the operation, then check latency, busy length and results.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edz, input logic eovf, input int poke);
    int lat;
    int bcnt;
    int exp_lat;
    exp_lat  = (b == 16'h0) ? 1 : 33;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = b ^ 16'h5A5A;
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      start = (lat == poke);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".busy_len"}, bcnt, exp_lat);
    chk({tag, ".done"}, {31'b0, done}, 32'd1);
    chk({tag, ".busy_at_done"}, {31'b0, busy}, 32'd0);
    chk({tag, ".quotient"}, {16'b0, quotient}, {16'b0, eq});
    chk({tag, ".remainder"}, {16'b0, remainder}, {16'b0, er});
    chk({tag, ".div_zero"}, {31'b0, div_zero}, {31'b0, edz});
    chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, eovf});
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  logic [31:0] bb_a [3] = '{32'd1000, 32'hFFFF8001, 32'h12345678};
  logic [15:0] bb_b [3] = '{16'hFFF6, 16'h0100, 16'h7FFF};
  logic [15:0] bb_q [3] = '{16'hFF9C, 16'hFF81, 16'h2468};
  logic [15:0] bb_r [3] = '{16'h0000, 16'hFF01, 16'h7AE0};

  initial begin
    int extra;
    int gap;

    #1;
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.quotient", {16'b0, quotient}, 32'd0);
    chk("rst.remainder", {16'b0, remainder}, 32'd0);
    chk("rst.flags", {30'b0, div_zero, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("p100_7",   32'd100,      16'd7,      16'h000E, 16'h0002, 1'b0, 1'b0, -1);
    run_op("m100_7",   32'hFFFFFF9C, 16'd7,      16'hFFF2, 16'hFFFE, 1'b0, 1'b0, -1);
    run_op("p100_m7",  32'd100,      16'hFFF9,   16'hFFF2, 16'h0002, 1'b0, 1'b0, -1);
    run_op("m7_2",     32'hFFFFFFF9, 16'd2,      16'hFFFD, 16'hFFFF, 1'b0, 1'b0, -1);
    run_op("qmin",     32'h40000000, 16'h8000,   16'h8000, 16'h0000, 1'b0, 1'b0, -1);
    run_op("qpos_ovf", 32'hC0000000, 16'h8000,   16'h8000, 16'h0000, 1'b0, 1'b1, -1);
    run_op("max_1",    32'h7FFFFFFF, 16'd1,      16'h8000, 16'h0000, 1'b0, 1'b1, -1);
    run_op("min_m1",   32'h80000000, 16'hFFFF,   16'h8000, 16'h0000, 1'b0, 1'b1, -1);
    run_op("dz",       32'd1234,     16'd0,      16'h0000, 16'h0000, 1'b1, 1'b0, -1);
    run_op("p9_3",     32'd9,        16'd3,      16'h0003, 16'h0000, 1'b0, 1'b0, -1);

    run_op("poke",     32'd100,      16'd7,      16'h000E, 16'h0002, 1'b0, 1'b0, 10);
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk("poke.no_queued_done", extra, 0);

    dividend = 32'd200;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("abort.busy", {31'b0, busy}, 32'd0);
    chk("abort.done", {31'b0, done}, 32'd0);
    chk("abort.quotient", {16'b0, quotient}, 32'd0);
    chk("abort.remainder", {16'b0, remainder}, 32'd0);
    chk("abort.flags", {30'b0, div_zero, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk("abort.no_done", extra, 0);
    run_op("p50_5",    32'd50,       16'd5,      16'h000A, 16'h0000, 1'b0, 1'b0, -1);

    dividend = bb_a[0];
    divisor  = bb_b[0];
    start    = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      gap = 0;
      while (!done && gap < 100) begin
        @(posedge clk); #1;
        gap++;
      end
      chk($sformatf("b2b%0d.latency", i), gap, 33);
      chk($sformatf("b2b%0d.quotient", i), {16'b0, quotient}, {16'b0, bb_q[i]});
      chk($sformatf("b2b%0d.remainder", i), {16'b0, remainder}, {16'b0, bb_r[i]});
      chk($sformatf("b2b%0d.flags", i), {30'b0, div_zero, overflow}, 32'd0);
      if (i < 2) begin
        dividend = bb_a[i+1];
        divisor  = bb_b[i+1];
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("b2b%0d.done_pulse", i), {31'b0, done}, 32'd0);
      chk($sformatf("b2b%0d.busy_next", i), {31'b0, busy}, (i < 2) ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
